// File: rtl/video_timing_gen.sv
// Free-running raster timing generator with line doubling: hcnt/line counters plus
// registered sync, blanking and line-advance strobes, all updated on the same edge.
module video_timing_gen #(
  parameter int H_ACTIVE = 704,
  parameter int H_FRONT  = 26,
  parameter int H_SYNC   = 106,
  parameter int H_BACK   = 74,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [9:0] hpos,
  output logic       hsync,
  output logic       hblank,
  output logic       hlast,
  output logic [7:0] vpos,
  output logic       vsync,
  output logic       vblank,
  output logic       vnext,
  output logic       blank
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_params
      $error("video_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
  endgenerate

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] LINE_SAT = 10'd512;

  logic [9:0] hcnt, line;
  logic [9:0] hcnt_nxt, line_nxt, line_after;
  logic [7:0] vpos_nxt, vpos_after;
  logic       hlast_nxt, hblank_nxt, vblank_nxt, hsync_on, vsync_on;

  assign hpos = hcnt;

  always_comb begin
    hcnt_nxt = (hcnt == H_LAST) ? 10'd0 : hcnt + 10'd1;
    line_nxt = line;
    if (hcnt == H_LAST) begin
      line_nxt = (line == V_LAST) ? 10'd0 : line + 10'd1;
    end
    line_after = (line_nxt == V_LAST) ? 10'd0 : line_nxt + 10'd1;
  end

  // Logical line saturates at 255 so line-compare consumers never re-match inside vblank.
  always_comb begin
    vpos_nxt   = (line_nxt   >= LINE_SAT) ? 8'hFF : 8'(line_nxt   >> 1);
    vpos_after = (line_after >= LINE_SAT) ? 8'hFF : 8'(line_after >> 1);
    hlast_nxt  = (hcnt_nxt == H_LAST);
    hblank_nxt = (hcnt_nxt >= H_ACT);
    vblank_nxt = (line_nxt >= V_ACT);
    hsync_on   = (hcnt_nxt >= HS_START) && (hcnt_nxt <= HS_END);
    vsync_on   = (line_nxt >= VS_START) && (line_nxt <= VS_END);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt   <= '0;
      line   <= '0;
      hsync  <= ~SYNC_POL;
      hblank <= 1'b0;
      hlast  <= 1'b0;
      vpos   <= '0;
      vsync  <= ~SYNC_POL;
      vblank <= 1'b0;
      vnext  <= 1'b0;
      blank  <= 1'b0;
    end else begin
      hcnt   <= hcnt_nxt;
      line   <= line_nxt;
      hsync  <= hsync_on ? SYNC_POL : ~SYNC_POL;
      hblank <= hblank_nxt;
      hlast  <= hlast_nxt;
      vpos   <= vpos_nxt;
      vsync  <= vsync_on ? SYNC_POL : ~SYNC_POL;
      vblank <= vblank_nxt;
      vnext  <= hlast_nxt && (vpos_nxt != vpos_after);
      blank  <= hblank_nxt | vblank_nxt;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: three generators (default, short-line for full frames, 640-wide override);
// expected per-line and per-frame records are queued up front and popped by a monitor.
module tb_video_timing_gen;

  localparam int ND = 3;
  localparam int HA [ND] = '{704, 8, 640};
  localparam int HF [ND] = '{26,  2, 16};
  localparam int HS [ND] = '{106, 3, 96};
  localparam int HT [ND] = '{910, 16, 800};

  typedef struct packed {
    int period;
    int sync_cnt;
    int sync_first;
    int sync_last;
    int hblank_cnt;
    int vpos_first;
    int vpos_last;
    int vnext;
    int vsync_cnt;
    int vblank_cnt;
    int bad;
  } line_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] hpos   [ND];
  logic [7:0] vpos   [ND];
  logic       hsync  [ND];
  logic       hblank [ND];
  logic       hlast  [ND];
  logic       vsync  [ND];
  logic       vblank [ND];
  logic       vnext  [ND];
  logic       blank  [ND];

  int vectors = 0;
  int miscompares = 0;

  line_t exp_q   [ND][$];
  int    frame_q [ND][$];

  always #5 clk = ~clk;

  video_timing_gen u_def (
    .clk(clk), .reset_n(reset_n), .hpos(hpos[0]), .hsync(hsync[0]), .hblank(hblank[0]),
    .hlast(hlast[0]), .vpos(vpos[0]), .vsync(vsync[0]), .vblank(vblank[0]),
    .vnext(vnext[0]), .blank(blank[0]));

  video_timing_gen #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3)) u_vid (
    .clk(clk), .reset_n(reset_n), .hpos(hpos[1]), .hsync(hsync[1]), .hblank(hblank[1]),
    .hlast(hlast[1]), .vpos(vpos[1]), .vsync(vsync[1]), .vblank(vblank[1]),
    .vnext(vnext[1]), .blank(blank[1]));

  video_timing_gen #(.H_ACTIVE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48)) u_ovr (
    .clk(clk), .reset_n(reset_n), .hpos(hpos[2]), .hsync(hsync[2]), .hblank(hblank[2]),
    .hlast(hlast[2]), .vpos(vpos[2]), .vsync(vsync[2]), .vblank(vblank[2]),
    .vnext(vnext[2]), .blank(blank[2]));

  function automatic line_t clr();
    line_t l;
    l = '0;
    l.sync_first = -1;
    l.sync_last  = -1;
    return l;
  endfunction

  // Expected record for output line l of dut d; line 511 -> 512 keeps vpos at 255, so no vnext there.
  function automatic line_t exp_line(int d, int l);
    line_t e;
    int    vp;
    vp           = (l < 512) ? l / 2 : 255;
    e            = '0;
    e.period     = HT[d];
    e.sync_cnt   = HS[d];
    e.sync_first = HA[d] + HF[d];
    e.sync_last  = HA[d] + HF[d] + HS[d] - 1;
    e.hblank_cnt = HT[d] - HA[d];
    e.vpos_first = vp;
    e.vpos_last  = vp;
    e.vnext      = (((l % 2) == 1 && l <= 509) || l == 524) ? 1 : 0;
    e.vsync_cnt  = (l == 490 || l == 491) ? HT[d] : 0;
    e.vblank_cnt = (l >= 480) ? HT[d] : 0;
    e.bad        = 0;
    return e;
  endfunction

  function automatic string fmt(line_t l);
    return $sformatf("per=%0d hs=%0d[%0d..%0d] hb=%0d vp=%0d/%0d vn=%0d vs=%0d vb=%0d bad=%0d",
                     l.period, l.sync_cnt, l.sync_first, l.sync_last, l.hblank_cnt,
                     l.vpos_first, l.vpos_last, l.vnext, l.vsync_cnt, l.vblank_cnt, l.bad);
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: accumulates one line per dut, compares at each hlast and at each vblank rise.
  initial begin
    line_t acc [ND];
    bit    partial [ND];
    bit    armed [ND];
    int    fcnt [ND];
    logic  vblank_d [ND];
    line_t e;
    int    ef;
    for (int d = 0; d < ND; d++) begin
      acc[d] = clr(); partial[d] = 1'b1; armed[d] = 1'b0; fcnt[d] = 0; vblank_d[d] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        if (!reset_n) begin
          acc[d] = clr(); partial[d] = 1'b1; armed[d] = 1'b0; fcnt[d] = 0; vblank_d[d] = 1'b0;
        end else begin
          if (vblank[d] && !vblank_d[d]) begin
            if (armed[d] && frame_q[d].size() > 0) begin
              ef = frame_q[d].pop_front();
              vectors++;
              if (fcnt[d] != ef) begin
                miscompares++;
                $display("FAIL frame dut%0d: hlast count %0d expected %0d", d, fcnt[d], ef);
              end
            end
            armed[d] = 1'b1;
            fcnt[d]  = 0;
          end
          vblank_d[d] = vblank[d];
          if (acc[d].period == 0) acc[d].vpos_first = int'(vpos[d]);
          acc[d].period++;
          if (hsync[d] == 1'b0) begin
            acc[d].sync_cnt++;
            if (acc[d].sync_first < 0) acc[d].sync_first = int'(hpos[d]);
            acc[d].sync_last = int'(hpos[d]);
          end
          if (hblank[d]) acc[d].hblank_cnt++;
          if (vsync[d] == 1'b0) acc[d].vsync_cnt++;
          if (vblank[d]) acc[d].vblank_cnt++;
          if (blank[d] !== (hblank[d] | vblank[d])) acc[d].bad++;
          if (hblank[d] !== (int'(hpos[d]) >= HA[d])) acc[d].bad++;
          if (hlast[d] !== (int'(hpos[d]) == HT[d] - 1)) acc[d].bad++;
          if (vnext[d] && !hlast[d]) acc[d].bad++;
          if (hlast[d]) begin
            acc[d].vpos_last = int'(vpos[d]);
            acc[d].vnext     = vnext[d] ? 1 : 0;
            fcnt[d]++;
            if (!partial[d] && exp_q[d].size() > 0) begin
              e = exp_q[d].pop_front();
              vectors++;
              if (acc[d] != e) begin
                miscompares++;
                $display("FAIL line dut%0d: got %s | exp %s", d, fmt(acc[d]), fmt(e));
              end
            end
            partial[d] = 1'b0;
            acc[d]     = clr();
          end
        end
      end
    end
  end

  initial begin
    int pending;
    int budget;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++)
      chk($sformatf("reset_pwrup_dut%0d", d),
          64'({hpos[d], vpos[d], hsync[d], hblank[d], hlast[d], vsync[d], vblank[d], vnext[d], blank[d]}),
          64'({10'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("count_%0d", i), 64'({hpos[0], hpos[1], hpos[2]}),
          64'({10'(i), 10'(i), 10'(i)}));
    end
    // 1210 edges after release: def line 1 hpos 300, vid line 75 hpos 10, ovr line 1 hpos 410.
    repeat (1207) @(negedge clk);
    chk("pre_reset_def", 64'({hpos[0], vpos[0]}), 64'({10'd300, 8'd0}));
    chk("pre_reset_vid", 64'({hpos[1], vpos[1]}), 64'({10'd10, 8'd37}));
    chk("pre_reset_ovr", 64'({hpos[2], vpos[2]}), 64'({10'd410, 8'd0}));

    #2 reset_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++)
      chk($sformatf("reset_midframe_dut%0d", d),
          64'({hpos[d], vpos[d], hsync[d], hblank[d], hlast[d], vsync[d], vblank[d], vnext[d], blank[d]}),
          64'({10'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));

    for (int l = 1; l <= 4; l++) exp_q[0].push_back(exp_line(0, l));
    for (int l = 1; l <= 1014; l++) exp_q[1].push_back(exp_line(1, l % 525));
    for (int l = 1; l <= 5; l++) exp_q[2].push_back(exp_line(2, l));
    frame_q[1].push_back(525);

    repeat (2) @(negedge clk);
    chk("reset_hold", 64'({hpos[0], hpos[1], hpos[2]}), 64'd0);
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("recount_%0d", i), 64'({hpos[0], hpos[1], hpos[2]}),
          64'({10'(i), 10'(i), 10'(i)}));
    end

    budget = 0;
    pending = 1;
    while (pending != 0 && budget < 20000) begin
      @(negedge clk);
      budget++;
      pending = 0;
      for (int d = 0; d < ND; d++) pending += exp_q[d].size() + frame_q[d].size();
    end
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("lines_left_dut%0d", d), 64'(exp_q[d].size()), 64'd0);
      chk($sformatf("frames_left_dut%0d", d), 64'(frame_q[d].size()), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
